pipe_stage_skid_reg: RTL and testbench

Parametrised successor of the IF/ID pipeline register. It carries a PC, an instruction and a side-band payload between any two pipeline stages. It uses a valid/ready handshake with an optional 2-entry skid buffer, so the ready path is fully registered. A flush inserts a NOP bubble. Instantiated at IF/ID first, then ID/EX and EX/MEM with different payload widths.

---
 rtl/rvseed_pipe_pkg.sv | 19 +
 rtl/pipe_stage_skid_reg_if.sv | 32 +++
 rtl/pipe_skid_entry.sv | 30 +++
 rtl/pipe_stage_skid_reg.sv | 78 +++++++
 tb/tb_pipe_stage_skid_reg.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvseed_pipe_pkg.sv
// Shared definitions for the pipeline-stage registers.
// RESET_PC / NOP_INSTR are the architectural reset PC and the bubble
// instruction (addi x0,x0,0). pipe_payload_t is the default-width payload
// carried across a stage boundary.
package rvseed_pipe_pkg;
  localparam logic [63:0] RESET_PC  = 64'h8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [7:0]  side;
  } pipe_payload_t;

  // Number of held entries from the two slot valid bits.
  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle between two pipeline stages.
//   in_*  : upstream valid/ready + payload (pc, instr, side)
//   out_* : downstream valid/ready + payload
//   flush : kill all held entries; occupancy : entries held (0..2)
// slave = the stage register, master = the driving environment.
interface pipe_stage_skid_reg_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int SIDE_W  = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic [SIDE_W-1:0]  in_side;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [SIDE_W-1:0]  out_side;
  logic               flush;
  logic [1:0]         occupancy;

  modport slave (
    input  in_valid, in_pc, in_instr, in_side, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, out_side, occupancy
  );
  modport master (
    output in_valid, in_pc, in_instr, in_side, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, out_side, occupancy
  );
endinterface

// File: rtl/pipe_skid_entry.sv
// One payload slot with a valid bit.
//   clk, rst : clock, synchronous active-high reset (q <= RST_VAL)
//   load     : capture d and mark valid
//   clr      : drop the entry; q keeps its value so a held PC stays visible
//   vld, q   : slot state
// clr wins over load so a flush discards a payload arriving the same cycle.
module pipe_skid_entry #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= RST_VAL;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Generic pipeline stage register (IF/ID, ID/EX, EX/MEM).
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pipe_stage_skid_reg_if (in_*, out_*, flush,
//              occupancy)
// SKID=1: main + skid slot, in_ready comes only from skid state (no path
// from out_ready). SKID=0: one slot, in_ready = ~main_valid | out_ready.
// Outputs show a NOP bubble whenever out_valid=0; out_pc holds.
module pipe_stage_skid_reg
  import rvseed_pipe_pkg::*;
#(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter int                 SIDE_W    = 8,
  parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(rvseed_pipe_pkg::RESET_PC),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(rvseed_pipe_pkg::NOP_INSTR),
  parameter bit                 SKID      = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  pipe_stage_skid_reg_if.slave bus
);
  localparam int           W         = PC_W + INSTR_W + SIDE_W;
  localparam logic [W-1:0] ENTRY_RST = {RESET_PC, NOP_INSTR, {SIDE_W{1'b0}}};

  logic [W-1:0] in_pl, main_q, main_d;
  logic         main_vld, skid_vld, main_load, main_clr, acc, iss;

  assign in_pl = {bus.in_pc, bus.in_instr, bus.in_side};
  assign acc   = bus.in_valid & bus.in_ready;
  assign iss   = main_vld & bus.out_ready;

  generate
    if (SKID) begin : g_skid
      logic [W-1:0] skid_q;
      logic         skid_load, skid_clr;
      assign bus.in_ready = ~skid_vld & ~rst;
      // Skid only fills when main is stalled; on issue it drains into main
      // before anything new is taken, which keeps FIFO order.
      assign skid_load = acc & main_vld & ~iss;
      assign skid_clr  = bus.flush | (skid_vld & iss);
      assign main_load = skid_vld ? iss : (acc & (~main_vld | iss));
      assign main_d    = skid_vld ? skid_q : in_pl;
      pipe_skid_entry #(.W(W), .RST_VAL(ENTRY_RST)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .clr  (skid_clr),
        .d    (in_pl),
        .vld  (skid_vld),
        .q    (skid_q)
      );
    end else begin : g_single
      assign bus.in_ready = (~main_vld | bus.out_ready) & ~rst;
      assign main_load    = acc;
      assign main_d       = in_pl;
      assign skid_vld     = 1'b0;
    end
  endgenerate

  // Issue without a refill empties main; flush overrides any load.
  assign main_clr = bus.flush | (iss & ~main_load);

  pipe_skid_entry #(.W(W), .RST_VAL(ENTRY_RST)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .clr  (main_clr),
    .d    (main_d),
    .vld  (main_vld),
    .q    (main_q)
  );

  assign bus.out_valid = main_vld;
  assign bus.out_pc    = main_q[W-1 -: PC_W];
  assign bus.out_instr = main_vld ? main_q[SIDE_W +: INSTR_W] : NOP_INSTR;
  assign bus.out_side  = main_vld ? main_q[SIDE_W-1:0] : '0;
  assign bus.occupancy = occ_count(main_vld, skid_vld);
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;
  import rvseed_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: SKID=1 instance, index 1: SKID=0 instance
  logic        rst_v [2];
  logic        iv_v  [2];
  logic        ordy_v[2];
  logic        fl_v  [2];
  logic [63:0] pc_v  [2];
  logic [31:0] ins_v [2];
  logic [7:0]  side_v[2];

  logic        rdy_o [2];
  logic        ov_o  [2];
  logic [63:0] pc_o  [2];
  logic [31:0] ins_o [2];
  logic [7:0]  side_o[2];
  logic [1:0]  occ_o [2];

  pipe_stage_skid_reg_if bus0 ();
  pipe_stage_skid_reg_if bus1 ();

  assign bus0.in_valid = iv_v[0];  assign bus1.in_valid = iv_v[1];
  assign bus0.in_pc    = pc_v[0];  assign bus1.in_pc    = pc_v[1];
  assign bus0.in_instr = ins_v[0]; assign bus1.in_instr = ins_v[1];
  assign bus0.in_side  = side_v[0]; assign bus1.in_side = side_v[1];
  assign bus0.out_ready = ordy_v[0]; assign bus1.out_ready = ordy_v[1];
  assign bus0.flush    = fl_v[0];  assign bus1.flush    = fl_v[1];

  assign rdy_o[0] = bus0.in_ready;  assign rdy_o[1] = bus1.in_ready;
  assign ov_o[0]  = bus0.out_valid; assign ov_o[1]  = bus1.out_valid;
  assign pc_o[0]  = bus0.out_pc;    assign pc_o[1]  = bus1.out_pc;
  assign ins_o[0] = bus0.out_instr; assign ins_o[1] = bus1.out_instr;
  assign side_o[0] = bus0.out_side; assign side_o[1] = bus1.out_side;
  assign occ_o[0] = bus0.occupancy; assign occ_o[1] = bus1.occupancy;

  pipe_stage_skid_reg #(.SKID(1'b1)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
  pipe_stage_skid_reg #(.SKID(1'b0)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));

  int tot = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: an in-order queue of at most 2 (SKID=1) or 1 (SKID=0)
  // payloads. Front of queue is what the stage presents.
  pipe_payload_t mbuf[2][2];
  int            mcnt[2];
  logic [63:0]   mpc [2];
  logic          macc[2];
  bit            mchk = 1'b0;

  function automatic logic mrdy(input int k);
    if (rst_v[k]) return 1'b0;
    if (k == 0) return mcnt[k] < 2;
    return (mcnt[k] == 0) || ordy_v[k];
  endfunction

  task automatic model_edge(input int k);
    if (rst_v[k]) begin
      mcnt[k] = 0;
      mpc[k]  = RESET_PC;
    end else if (fl_v[k]) begin
      mcnt[k] = 0;
    end else begin
      if (mcnt[k] > 0 && ordy_v[k]) begin
        mbuf[k][0] = mbuf[k][1];
        mcnt[k]--;
      end
      if (macc[k]) begin
        mbuf[k][mcnt[k]] = '{pc: pc_v[k], instr: ins_v[k], side: side_v[k]};
        mcnt[k]++;
      end
      if (mcnt[k] > 0) mpc[k] = mbuf[k][0].pc;
    end
  endtask

  // Pre-edge snapshots and upstream-hold tracking
  logic        pre_rdy[2], pre_ov[2];
  logic [63:0] pre_pc[2];
  logic [31:0] pre_ins[2];
  logic        hold_prev[2];
  logic [63:0] hpc[2];
  logic [31:0] hins[2];
  logic [7:0]  hside[2];

  // Inputs are set before calling; checks combinational values mid-cycle,
  // advances one edge, then checks registered outputs 1ns after the edge.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (hold_prev[k] && !rst_v[k]) begin
        chk($sformatf("hold%0d_valid", k), 64'(iv_v[k]), 64'd1);
        chk($sformatf("hold%0d_payload", k), {pc_v[k] ^ hpc[k]} | 64'(ins_v[k] ^ hins[k]) | 64'(side_v[k] ^ hside[k]), 64'd0);
      end
      macc[k]    = iv_v[k] && mrdy(k);
      pre_rdy[k] = rdy_o[k];
      pre_ov[k]  = ov_o[k];
      pre_pc[k]  = pc_o[k];
      pre_ins[k] = ins_o[k];
      hold_prev[k] = iv_v[k] && !rdy_o[k] && !rst_v[k];
      hpc[k] = pc_v[k]; hins[k] = ins_v[k]; hside[k] = side_v[k];
      if (mchk) chk($sformatf("rnd%0d_in_ready", k), 64'(rdy_o[k]), 64'(mrdy(k)));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    if (mchk) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d_out_valid", k), 64'(ov_o[k]), 64'(mcnt[k] > 0));
        chk($sformatf("rnd%0d_out_pc", k), pc_o[k], mpc[k]);
        chk($sformatf("rnd%0d_out_instr", k), 64'(ins_o[k]),
            64'((mcnt[k] > 0) ? mbuf[k][0].instr : NOP_INSTR));
        chk($sformatf("rnd%0d_out_side", k), 64'(side_o[k]),
            64'((mcnt[k] > 0) ? mbuf[k][0].side : 8'h00));
        chk($sformatf("rnd%0d_occupancy", k), 64'(occ_o[k]), 64'(mcnt[k]));
      end
      chk("rnd1_occ_le1", 64'(occ_o[1] <= 2'd1), 64'd1);
    end
  endtask

  typedef struct {
    logic rst, iv; logic [63:0] pc; logic [31:0] ins; logic [7:0] side;
    logic ordy, fl;
    logic erdy, ev; logic [63:0] epc; logic [31:0] eins; logic [7:0] eside;
    logic [1:0] eocc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [63:0] pc,
      input logic [31:0] ins, input logic [7:0] sd, input logic ordy, input logic fl,
      input logic erdy, input logic ev, input logic [63:0] epc, input logic [31:0] eins,
      input logic [7:0] esd, input logic [1:0] eocc);
    vec_t v;
    v.rst = r; v.iv = iv; v.pc = pc; v.ins = ins; v.side = sd; v.ordy = ordy; v.fl = fl;
    v.erdy = erdy; v.ev = ev; v.epc = epc; v.eins = eins; v.eside = esd; v.eocc = eocc;
    return v;
  endfunction

  task automatic idle(input int k, input logic r);
    rst_v[k] = r; iv_v[k] = 1'b0; ordy_v[k] = 1'b0; fl_v[k] = 1'b0;
    pc_v[k] = '0; ins_v[k] = '0; side_v[k] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[18];
    int sent, got;
    logic pend[2];
    logic [63:0] seqpc[2];

    for (int k = 0; k < 2; k++) begin
      idle(k, 1'b1);
      mcnt[k] = 0; mpc[k] = RESET_PC; hold_prev[k] = 1'b0;
    end

    // ---- table vectors on the SKID=1 stage ----
    //          rst iv pc             instr         side ordy fl | rdy v  pc             instr         side occ
    vt[0]  = mk(1, 0, 64'h0,          32'h0,        8'h0, 0, 0,   0, 0, 64'h8000_0000, 32'h13,       8'h0, 0);
    vt[1]  = mk(0, 1, 64'h8000_0004, 32'h0050_0093, 8'h5, 1, 0,   1, 1, 64'h8000_0004, 32'h0050_0093, 8'h5, 1);
    vt[2]  = mk(0, 0, 64'h0,          32'h0,        8'h0, 1, 0,   1, 0, 64'h8000_0004, 32'h13,       8'h0, 0);
    vt[3]  = mk(0, 1, 64'h8000_0000, 32'h0010_0093, 8'h1, 0, 0,   1, 1, 64'h8000_0000, 32'h0010_0093, 8'h1, 1);
    vt[4]  = mk(0, 1, 64'h8000_0004, 32'h0020_0113, 8'h2, 0, 0,   1, 1, 64'h8000_0000, 32'h0010_0093, 8'h1, 2);
    vt[5]  = mk(0, 1, 64'h8000_0008, 32'h0030_0193, 8'h3, 0, 0,   0, 1, 64'h8000_0000, 32'h0010_0093, 8'h1, 2);
    vt[6]  = mk(0, 1, 64'h8000_0008, 32'h0030_0193, 8'h3, 1, 0,   0, 1, 64'h8000_0004, 32'h0020_0113, 8'h2, 1);
    vt[7]  = mk(0, 1, 64'h8000_0008, 32'h0030_0193, 8'h3, 1, 0,   1, 1, 64'h8000_0008, 32'h0030_0193, 8'h3, 1);
    vt[8]  = mk(0, 1, 64'h8000_000C, 32'h0040_0213, 8'h4, 0, 0,   1, 1, 64'h8000_0008, 32'h0030_0193, 8'h3, 2);
    vt[9]  = mk(0, 1, 64'h8000_0010, 32'h0050_0293, 8'h6, 0, 1,   0, 0, 64'h8000_0008, 32'h13,       8'h0, 0);
    vt[10] = mk(0, 1, 64'h8000_0010, 32'h0050_0293, 8'h6, 1, 1,   1, 0, 64'h8000_0008, 32'h13,       8'h0, 0);
    vt[11] = mk(0, 1, 64'h8000_0014, 32'h0060_0313, 8'h7, 0, 0,   1, 1, 64'h8000_0014, 32'h0060_0313, 8'h7, 1);
    vt[12] = mk(0, 1, 64'h8000_0018, 32'h0070_0393, 8'h8, 0, 0,   1, 1, 64'h8000_0014, 32'h0060_0313, 8'h7, 2);
    vt[13] = mk(1, 0, 64'h0,          32'h0,        8'h0, 0, 0,   0, 0, 64'h8000_0000, 32'h13,       8'h0, 0);
    vt[14] = mk(1, 0, 64'h0,          32'h0,        8'h0, 0, 0,   0, 0, 64'h8000_0000, 32'h13,       8'h0, 0);
    vt[15] = mk(0, 0, 64'h0,          32'h0,        8'h0, 0, 0,   1, 0, 64'h8000_0000, 32'h13,       8'h0, 0);
    vt[16] = mk(0, 1, 64'h8000_0020, 32'h0080_0413, 8'h9, 0, 0,   1, 1, 64'h8000_0020, 32'h0080_0413, 8'h9, 1);
    vt[17] = mk(0, 0, 64'h0,          32'h0,        8'h0, 1, 1,   1, 0, 64'h8000_0020, 32'h13,       8'h0, 0);

    for (int i = 0; i < 18; i++) begin
      rst_v[0] = vt[i].rst; iv_v[0] = vt[i].iv; pc_v[0] = vt[i].pc;
      ins_v[0] = vt[i].ins; side_v[0] = vt[i].side;
      ordy_v[0] = vt[i].ordy; fl_v[0] = vt[i].fl;
      cycle();
      chk($sformatf("vec%0d_in_ready", i), 64'(pre_rdy[0]), 64'(vt[i].erdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(ov_o[0]), 64'(vt[i].ev));
      chk($sformatf("vec%0d_out_pc", i), pc_o[0], vt[i].epc);
      chk($sformatf("vec%0d_out_instr", i), 64'(ins_o[0]), 64'(vt[i].eins));
      chk($sformatf("vec%0d_out_side", i), 64'(side_o[0]), 64'(vt[i].eside));
      chk($sformatf("vec%0d_occupancy", i), 64'(occ_o[0]), 64'(vt[i].eocc));
    end

    // ---- 16-instruction stream, out_ready toggling every cycle ----
    idle(0, 1'b1);
    cycle();
    rst_v[0] = 1'b0;
    sent = 0; got = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      iv_v[0]   = (sent < 16);
      pc_v[0]   = 64'h8000_0000 + 64'(4 * sent);
      ins_v[0]  = 32'(sent);
      side_v[0] = 8'(sent);
      ordy_v[0] = (c % 2 == 0);
      cycle();
      if (pre_ov[0] && ordy_v[0]) begin
        chk($sformatf("stream_pc%0d", got), pre_pc[0], 64'h8000_0000 + 64'(4 * got));
        chk($sformatf("stream_instr%0d", got), 64'(pre_ins[0]), 64'(got));
        got++;
      end
      if (iv_v[0] && pre_rdy[0]) sent++;
    end
    chk("stream_count", 64'(got), 64'd16);
    iv_v[0] = 1'b0; ordy_v[0] = 1'b1;
    cycle();
    chk("stream_drained", 64'(ov_o[0]), 64'd0);

    // ---- SKID=0: combinational in_ready on simultaneous issue/accept ----
    idle(0, 1'b1);
    cycle();
    rst_v[1] = 1'b0;
    iv_v[1] = 1'b1; pc_v[1] = 64'h8000_0100; ins_v[1] = 32'h0000_0111; side_v[1] = 8'h11;
    ordy_v[1] = 1'b1;
    cycle();
    chk("s0_first_ready", 64'(pre_rdy[1]), 64'd1);
    chk("s0_first_pc", pc_o[1], 64'h8000_0100);
    pc_v[1] = 64'h8000_0104; ins_v[1] = 32'h0000_0222; side_v[1] = 8'h22;
    cycle();
    chk("s0_thru_ready", 64'(pre_rdy[1]), 64'd1);
    chk("s0_thru_valid", 64'(ov_o[1]), 64'd1);
    chk("s0_thru_pc", pc_o[1], 64'h8000_0104);
    chk("s0_thru_instr", 64'(ins_o[1]), 64'h222);
    chk("s0_thru_occ", 64'(occ_o[1]), 64'd1);
    pc_v[1] = 64'h8000_0108; ins_v[1] = 32'h0000_0333; side_v[1] = 8'h33;
    ordy_v[1] = 1'b0;
    cycle();
    chk("s0_stall_ready", 64'(pre_rdy[1]), 64'd0);
    chk("s0_stall_pc", pc_o[1], 64'h8000_0104);
    ordy_v[1] = 1'b1;
    cycle();
    chk("s0_resume_ready", 64'(pre_rdy[1]), 64'd1);
    chk("s0_resume_pc", pc_o[1], 64'h8000_0108);
    chk("s0_resume_side", 64'(side_o[1]), 64'h33);
    iv_v[1] = 1'b0;
    cycle();
    chk("s0_empty_valid", 64'(ov_o[1]), 64'd0);
    chk("s0_empty_instr", 64'(ins_o[1]), 64'h13);
    chk("s0_empty_occ", 64'(occ_o[1]), 64'd0);

    // ---- randomized traffic against the queue model, both variants ----
    idle(0, 1'b1); idle(1, 1'b1);
    mchk = 1'b1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0;
      seqpc[k] = 64'h8000_0000;
    end
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        rst_v[k]  = ($urandom_range(0, 99) == 0);
        fl_v[k]   = ($urandom_range(0, 15) == 0);
        ordy_v[k] = ($urandom_range(0, 2) != 0);
        if (!pend[k] && $urandom_range(0, 3) != 0) begin
          pend[k]   = 1'b1;
          pc_v[k]   = seqpc[k];
          seqpc[k]  = seqpc[k] + 64'd4;
          ins_v[k]  = $urandom;
          side_v[k] = 8'($urandom);
        end
        iv_v[k] = pend[k];
      end
      cycle();
      for (int k = 0; k < 2; k++)
        if (macc[k] || rst_v[k]) pend[k] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
